// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch (I) and load/store (D) requesters.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority, D over I.
module mem_arbiter #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_rw,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d, d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        pick_d;
`ifdef MEM_ARB_RR_EN
    logic        last_d_q, last_d_d;   // 1 = D port won the most recent grant
`endif

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < STARTING_ADDR) || (a > LAST_ADDR);
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        err_d     = err_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d_d  = last_d_q;
        pick_d    = d_req & (~i_req | ~last_d_q);
`else
        pick_d    = d_req;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d  = GNT_D;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    we_d     = d_we;
                    err_d    = addr_err(d_addr);
`ifdef MEM_ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d  = GNT_I;
                    addr_d   = i_addr;
                    we_d     = 1'b0;
                    err_d    = addr_err(i_addr);
`ifdef MEM_ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            GNT_I: begin
                state_d   = ACK;
                i_ack_d   = 1'b1;
                i_err_d   = err_q;
                i_rdata_d = mem_rdata;
            end
            GNT_D: begin
                state_d   = ACK;
                d_ack_d   = 1'b1;
                d_err_d   = err_q;
                d_rdata_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            err_q     <= err_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    // Reset gates the write strobe so a reset landing in GNT_D commits nothing.
    assign mem_rw    = (state_q == GNT_D) & we_q & ~err_q & ~reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;
endmodule
